dynamic_sieve_split: RTL and testbench

- Producer side of the dynamic sieve stream format. Takes one data word plus a stream of field lengths and emits one sieve command per field: {high_pos, low_pos, data}.
- Fields are packed LSB-first, so each field's low_pos is the running sum of the previous lengths.
- Sits in front of the sieve in field-extraction pipelines; the sieve masks each field out of the word.
- Registered output, one field per cycle throughput.

---
 rtl/dynamic_sieve_pkg.sv | 19 +
 rtl/dynamic_sieve_split_out_reg.sv | 30 +++
 rtl/dynamic_sieve_split.sv | 108 ++++++++++
 tb/tb_dynamic_sieve_split.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dynamic_sieve_pkg.sv
// Shared definitions for the dynamic sieve stream format.
// The split producer and the sieve consumer both use these so command layouts agree.
package dynamic_sieve_pkg;

    function automatic int unsigned pos_width(input int unsigned w_data);
        return $clog2(w_data) + 1;
    endfunction

    localparam int unsigned SIEVE_W_DATA = 16;
    localparam int unsigned SIEVE_W_POS  = pos_width(SIEVE_W_DATA);

    // One sieve command, MSB-first: {high_pos, low_pos, data}
    typedef struct packed {
        logic [SIEVE_W_POS-1:0]  high_pos;
        logic [SIEVE_W_POS-1:0]  low_pos;
        logic [SIEVE_W_DATA-1:0] data;
    } sieve_cmd_t;

endpackage

// File: rtl/dynamic_sieve_split_out_reg.sv
// One-entry valid/ready register slice (no bypass): registered output, full
// throughput when the downstream drains and reloads in the same cycle.
module dti_out_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/dynamic_sieve_split.sv
// Splits one data word into per-field sieve commands {high_pos, low_pos, data}, fields packed LSB-first.
// Define SIEVE_SPLIT_OVF_ERR_EN to add the sticky err output flagging field overruns.
module dynamic_sieve_split
    import dynamic_sieve_pkg::*;
#(
    parameter  int unsigned W_DATA = 16,
    localparam int unsigned W_POS  = pos_width(W_DATA)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W_DATA-1:0]         din_data,
    input  logic                      din_dvalid,
    output logic                      din_dready,
    input  logic [W_POS-1:0]          cfg_data,
    input  logic                      cfg_dvalid,
    input  logic                      cfg_eot,
    output logic                      cfg_dready,
    output logic [W_DATA+2*W_POS-1:0] dout_data,
    output logic                      dout_dvalid,
    output logic                      dout_eot,
    input  logic                      dout_dready
`ifdef SIEVE_SPLIT_OVF_ERR_EN
    ,
    output logic                      err
`endif
);

    localparam int unsigned    W_CMD = W_DATA + 2*W_POS;
    localparam logic [W_POS:0] TOP   = (W_POS+1)'(W_DATA);
    localparam logic [W_POS:0] ONE   = (W_POS+1)'(1);

    logic [W_POS-1:0] pos;
    logic [W_POS:0]   sum;
    logic [W_POS-1:0] high_pos;
    logic [W_POS-1:0] low_pos;
    logic             last;
    logic             reg_ready;
    logic             slot_ready;
    logic             fire;
    logic [W_CMD:0]   cmd_in;
    logic [W_CMD:0]   cmd_out;

    always_comb begin
        sum  = {1'b0, pos} + {1'b0, cfg_data};
        last = cfg_eot || (sum >= TOP);
        // A zero-length field encodes an empty mask: low above high.
        if (cfg_data == '0) begin
            low_pos  = W_POS'(W_DATA);
            high_pos = '0;
        end else begin
            low_pos  = pos;
            high_pos = (sum >= TOP) ? W_POS'(W_DATA - 1) : W_POS'(sum - ONE);
        end
    end

    assign slot_ready = reg_ready && !rst;
    assign fire       = din_dvalid && cfg_dvalid && slot_ready;
    assign cfg_dready = din_dvalid && slot_ready;
    assign din_dready = fire && last;
    assign cmd_in     = {high_pos, low_pos, din_data, last};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (fire) begin
            pos <= last ? '0 : sum[W_POS-1:0];
        end
    end

    dti_out_reg #(
        .W(W_CMD + 1)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .up_data  (cmd_in),
        .up_valid (fire),
        .up_ready (reg_ready),
        .dn_data  (cmd_out),
        .dn_valid (dout_dvalid),
        .dn_ready (dout_dready)
    );

    assign dout_data = cmd_out[W_CMD:1];
    assign dout_eot  = cmd_out[0];

`ifdef SIEVE_SPLIT_OVF_ERR_EN
    logic fill_pend;
    logic err_set;

    // After an exact fill without eot, a cfg entry waiting with no word behind it is a stray field.
    assign err_set = (fire && (sum > TOP)) || (fill_pend && cfg_dvalid && !din_dvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            fill_pend <= 1'b0;
        end else begin
            fill_pend <= fire && !cfg_eot && (sum == TOP);
            if (err_set) begin
                err <= 1'b1;
            end
            assert (!(err_set && !err))
                else $warning("dynamic_sieve_split: field overrun past word top");
        end
    end
`endif

endmodule

// File: tb/tb_dynamic_sieve_split.sv
// Self-checking bench for dynamic_sieve_split: directed scenarios plus randomized streams against a field-list model.
module tb_dynamic_sieve_split;
    import dynamic_sieve_pkg::*;

    localparam int WD = 16;
    localparam int WP = int'(pos_width(WD));
    localparam int WC = WD + 2*WP;

    typedef logic [WC:0] out_t;   // {high, low, data, eot}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WD-1:0] din_data = '0;
    logic          din_dvalid = 1'b0;
    logic          din_dready;
    logic [WP-1:0] cfg_data = '0;
    logic          cfg_dvalid = 1'b0;
    logic          cfg_eot = 1'b0;
    logic          cfg_dready;
    logic [WC-1:0] dout_data;
    logic          dout_dvalid;
    logic          dout_eot;
    logic          dout_dready = 1'b1;
`ifdef SIEVE_SPLIT_OVF_ERR_EN
    logic          err;
`endif

    dynamic_sieve_split #(
        .W_DATA(WD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_data    (din_data),
        .din_dvalid  (din_dvalid),
        .din_dready  (din_dready),
        .cfg_data    (cfg_data),
        .cfg_dvalid  (cfg_dvalid),
        .cfg_eot     (cfg_eot),
        .cfg_dready  (cfg_dready),
        .dout_data   (dout_data),
        .dout_dvalid (dout_dvalid),
        .dout_eot    (dout_eot),
        .dout_dready (dout_dready)
`ifdef SIEVE_SPLIT_OVF_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WD-1:0] words[$];
    int            cfg_len[$];
    bit            cfg_eot_q[$];
    out_t          exp_q[$];
    out_t          got_q[$];
    int            got_cyc[$];
    int            exp_rel;
    int            rel;
    bit            timed_out;
    bit            log_dv[$];
    bit            log_cr[$];
    logic [WC-1:0] log_dd[$];

    // Reference: walk the field list with a running position, one word per completed field group.
    function automatic void build_model();
        int pos = 0;
        int w = 0;
        exp_q.delete();
        exp_rel = 0;
        foreach (cfg_len[i]) begin
            int len;
            int sum;
            int lo;
            int hi;
            bit last;
            if (w >= words.size()) break;
            len = cfg_len[i];
            sum = pos + len;
            if (len == 0) begin
                lo = WD;
                hi = 0;
            end else begin
                lo = pos;
                hi = (sum - 1 < WD - 1) ? sum - 1 : WD - 1;
            end
            last = cfg_eot_q[i] || (sum >= WD);
            exp_q.push_back({WP'(hi), WP'(lo), words[w], last});
            if (last) begin
                pos = 0;
                w++;
                exp_rel++;
            end else begin
                pos = sum;
            end
        end
    endfunction

    // mode 0: always ready; 1: random ready and cfg gaps; 2: ready low for 5 cycles from stall_at
    task automatic run_stream(input int mode, input int stall_at, input int max_cyc);
        int wi = 0;
        int ci = 0;
        int cyc = 0;
        bit pend = 0;
        got_q.delete();
        got_cyc.delete();
        log_dv.delete();
        log_cr.delete();
        log_dd.delete();
        rel = 0;
        timed_out = 0;
        forever begin
            @(negedge clk);
            if ((ci == cfg_len.size() && !dout_dvalid) || cyc >= max_cyc) begin
                timed_out  = (cyc >= max_cyc);
                din_dvalid = 1'b0;
                cfg_dvalid = 1'b0;
                dout_dready = 1'b1;
                break;
            end
            din_dvalid = (wi < words.size());
            if (din_dvalid) din_data = words[wi];
            if (ci < cfg_len.size()) begin
                if (!pend) cfg_dvalid = (mode != 1) || ($urandom_range(3) != 0);
                cfg_data = WP'(cfg_len[ci]);
                cfg_eot  = cfg_eot_q[ci];
            end else begin
                cfg_dvalid = 1'b0;
                cfg_eot    = 1'b0;
            end
            if (mode == 1) dout_dready = ($urandom_range(3) != 0);
            else if (mode == 2) dout_dready = !(cyc >= stall_at && cyc < stall_at + 5);
            else dout_dready = 1'b1;
            #1;
            log_dv.push_back(dout_dvalid);
            log_cr.push_back(cfg_dready);
            log_dd.push_back(dout_data);
            if (cfg_dvalid && cfg_dready) begin
                ci++;
                pend = 0;
            end else begin
                pend = cfg_dvalid;
            end
            if (din_dready) begin
                wi++;
                rel++;
            end
            if (dout_dvalid && dout_dready) begin
                got_q.push_back({dout_data, dout_eot});
                got_cyc.push_back(cyc);
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        din_dvalid = 1'b1;
        din_data   = 16'hFFFF;
        cfg_dvalid = 1'b1;
        cfg_data   = WP'(4);
        repeat (2) @(negedge clk);
        #1;
        total++; if (dout_dvalid !== 1'b0) begin bad++; $display("FAIL reset_dvalid got=%b exp=0", dout_dvalid); end
        total++; if (din_dready !== 1'b0) begin bad++; $display("FAIL reset_din_dready got=%b exp=0", din_dready); end
        total++; if (cfg_dready !== 1'b0) begin bad++; $display("FAIL reset_cfg_dready got=%b exp=0", cfg_dready); end
`ifdef SIEVE_SPLIT_OVF_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
        @(negedge clk);
        din_dvalid = 1'b0;
        cfg_dvalid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        words = '{16'hBEEF};
        cfg_len = '{4, 4, 8};
        cfg_eot_q = '{0, 0, 1};
        build_model();
        run_stream(0, 0, 200);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (rel != exp_rel) begin bad++; $display("FAIL basic_release got=%0d exp=%0d", rel, exp_rel); end
    endtask

    task automatic test_back_to_back();
        words = '{16'h1234, 16'h5678};
        cfg_len = '{3, 5, 16};
        cfg_eot_q = '{0, 1, 1};
        build_model();
        run_stream(0, 0, 200);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b exp=0", timed_out); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (rel != exp_rel) begin bad++; $display("FAIL b2b_release got=%0d exp=%0d", rel, exp_rel); end
        if (got_cyc.size() == 3) begin
            total++; if (got_cyc[0] != 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=1", got_cyc[0]); end
            total++; if (got_cyc[2] - got_cyc[0] != 2) begin bad++; $display("FAIL b2b_no_bubble got=%0d exp=2", got_cyc[2] - got_cyc[0]); end
        end
    endtask

    task automatic test_zero_len();
        words = '{16'h9A7E};
        cfg_len = '{0, 6};
        cfg_eot_q = '{0, 1};
        build_model();
        run_stream(0, 0, 200);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout got=%b exp=0", timed_out); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL zero_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL zero_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        words = '{16'hC0DE};
        cfg_len = '{10, 10};
        cfg_eot_q = '{0, 0};
        build_model();
        run_stream(0, 0, 200);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL ovf_timeout got=%b exp=0", timed_out); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (rel != exp_rel) begin bad++; $display("FAIL ovf_release got=%0d exp=%0d", rel, exp_rel); end
`ifdef SIEVE_SPLIT_OVF_ERR_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", err); end
        repeat (4) @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got=%b exp=1", err); end
`endif
    endtask

    task automatic test_backpressure();
        words = '{16'h3C5A};
        cfg_len = '{2, 3, 4, 7};
        cfg_eot_q = '{0, 0, 0, 1};
        build_model();
        run_stream(2, 2, 200);
        for (int c = 2; c < 7; c++) if (c < log_dv.size()) begin
            total++; if (log_dv[c] !== 1'b1) begin bad++; $display("FAIL bp_dvalid_c%0d got=%b exp=1", c, log_dv[c]); end
            total++; if (log_cr[c] !== 1'b0) begin bad++; $display("FAIL bp_cfg_ready_c%0d got=%b exp=0", c, log_cr[c]); end
            total++; if (log_dd[c] !== exp_q[1][WC:1]) begin bad++; $display("FAIL bp_hold_c%0d got=%h exp=%h", c, log_dd[c], exp_q[1][WC:1]); end
        end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [WC-1:0] first;
        first = {WP'(3), WP'(0), 16'hA5C3};
        @(negedge clk);
        din_data = 16'hA5C3;
        din_dvalid = 1'b1;
        cfg_data = WP'(4);
        cfg_eot = 1'b0;
        cfg_dvalid = 1'b1;
        dout_dready = 1'b0;
        @(negedge clk);
        cfg_dvalid = 1'b0;
        #1;
        total++; if (dout_dvalid !== 1'b1) begin bad++; $display("FAIL rmw_pre_dvalid got=%b exp=1", dout_dvalid); end
        total++; if (dout_data !== first) begin bad++; $display("FAIL rmw_pre_data got=%h exp=%h", dout_data, first); end
        rst = 1'b1;
        #1;
        total++; if (dout_dvalid !== 1'b0) begin bad++; $display("FAIL rmw_dvalid got=%b exp=0", dout_dvalid); end
        total++; if (cfg_dready !== 1'b0) begin bad++; $display("FAIL rmw_cfg_ready got=%b exp=0", cfg_dready); end
`ifdef SIEVE_SPLIT_OVF_ERR_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rmw_err_clear got=%b exp=0", err); end
`endif
        @(negedge clk);
        rst = 1'b0;
        din_dvalid = 1'b0;
        dout_dready = 1'b1;
        words = '{16'hA5C3};
        cfg_len = '{4, 4, 8};
        cfg_eot_q = '{0, 0, 1};
        build_model();
        run_stream(0, 0, 200);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmw_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmw_field%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            words.delete();
            cfg_len.delete();
            cfg_eot_q.delete();
            for (int i = 0; i < 40; i++) words.push_back(WD'($urandom));
            for (int i = 0; i < 30; i++) begin
                cfg_len.push_back(($urandom_range(7) == 0) ? int'($urandom_range(20, 10)) : int'($urandom_range(9, 0)));
                cfg_eot_q.push_back(($urandom_range(3) == 0) || (i == 29));
            end
            build_model();
            run_stream(1, 0, 1500);
            total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL rnd%0d_timeout got=%b exp=0", r, timed_out); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_field%0d got=%h exp=%h", r, i, got_q[i], exp_q[i]); end
            end
            total++; if (rel != exp_rel) begin bad++; $display("FAIL rnd%0d_release got=%0d exp=%0d", r, rel, exp_rel); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_len();
        test_overrun();
        test_backpressure();
        test_reset_mid_word();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
